// File: rtl/y86_branch_predictor.sv
// Next-PC predictor: direct-mapped BTB of saturating counters, optional return stack (BPRED_RAS_EN), perf counters.
// Latency: prediction is combinational in the fetch cycle; training is visible to lookups from the next cycle.
// Backpressure: f_stall or !f_valid freezes all fetch-side state; execute-side training is never blocked.
module y86_branch_predictor #(
  parameter int ADDR_W     = 64,
  parameter int ENTRIES    = 16,
  parameter int CNT_W      = 2,
  parameter int MISS_TAKEN = 1,
  parameter int RAS_DEPTH  = 8,
  localparam int IDX_W     = $clog2(ENTRIES),
  localparam int RP_W      = $clog2(RAS_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_valid,
  input  logic              f_stall,
  input  logic [ADDR_W-1:0] f_pc,
  input  logic [3:0]        f_icode,
  input  logic [3:0]        f_ifun,
  input  logic [ADDR_W-1:0] f_valC,
  input  logic [ADDR_W-1:0] f_valP,
  output logic [ADDR_W-1:0] predPC,
  output logic              pred_taken,
  output logic [RP_W-1:0]   pred_ras_ptr,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_cnd,
  input  logic              upd_pred_taken,
  input  logic [RP_W-1:0]   upd_ras_ptr,
  output logic              mispredict,
  output logic [31:0]       lookup_cnt,
  output logic [31:0]       mispred_cnt
);

  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_LOW  = CNT_HALF - CNT_W'(1);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [CNT_W-1:0] cnt;
  } btb_entry_t;

  btb_entry_t btb [ENTRIES];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit;
  logic             fetch_act;
  logic             is_cond_jxx;
  logic             ras_hit;
  logic [ADDR_W-1:0] ras_top;

  assign f_idx = f_pc[IDX_W-1:0];
  assign f_tag = f_pc[ADDR_W-1:IDX_W];
  assign u_idx = upd_pc[IDX_W-1:0];
  assign u_tag = upd_pc[ADDR_W-1:IDX_W];
  assign f_hit = btb[f_idx].vld && (btb[f_idx].tag == f_tag);
  assign u_hit = btb[u_idx].vld && (btb[u_idx].tag == u_tag);

  assign fetch_act   = f_valid && !f_stall;
  assign is_cond_jxx = (f_icode == 4'h7) && (f_ifun != 4'h0);
  assign mispredict  = upd_valid && (upd_cnd != upd_pred_taken);

  always_comb begin
    predPC     = f_valP;
    pred_taken = 1'b0;
    case (f_icode)
      4'h7: begin
        if (f_ifun == 4'h0)  pred_taken = 1'b1;
        else if (f_hit)      pred_taken = btb[f_idx].cnt[CNT_W-1];
        else                 pred_taken = (MISS_TAKEN != 0);
        if (pred_taken) predPC = f_valC;
      end
      4'h8: begin
        pred_taken = 1'b1;
        predPC     = f_valC;
      end
      4'h9: begin
        if (ras_hit) begin
          pred_taken = 1'b1;
          predPC     = ras_top;
        end
      end
      default: ;
    endcase
  end

  // No bypass: a same-cycle lookup sees the table as it was before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) btb[i] <= '0;
      lookup_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (upd_valid) begin
        if (u_hit) begin
          if (upd_cnd && btb[u_idx].cnt != CNT_MAX)
            btb[u_idx].cnt <= btb[u_idx].cnt + CNT_W'(1);
          else if (!upd_cnd && btb[u_idx].cnt != '0)
            btb[u_idx].cnt <= btb[u_idx].cnt - CNT_W'(1);
        end else begin
          btb[u_idx].vld <= 1'b1;
          btb[u_idx].tag <= u_tag;
          btb[u_idx].cnt <= upd_cnd ? CNT_HALF : CNT_LOW;
        end
      end
      if (fetch_act && is_cond_jxx && lookup_cnt != '1)
        lookup_cnt <= lookup_cnt + 32'd1;
      if (mispredict && mispred_cnt != '1)
        mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

`ifdef BPRED_RAS_EN
  localparam int RAS_IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [RP_W-1:0]   ras_ptr;
  logic              ras_push, ras_pop;

  assign ras_hit      = (ras_ptr != '0);
  assign ras_top      = ras_mem[RAS_IDX_W'(ras_ptr - RP_W'(1))];
  assign ras_push     = fetch_act && (f_icode == 4'h8) && (ras_ptr != RP_W'(RAS_DEPTH));
  assign ras_pop      = fetch_act && (f_icode == 4'h9) && ras_hit;
  assign pred_ras_ptr = ras_ptr;

  // A resolving mispredict rewinds the stack and discards this cycle's push/pop.
  always_ff @(posedge clk) begin
    if (reset)           ras_ptr <= '0;
    else if (mispredict) ras_ptr <= upd_ras_ptr;
    else if (ras_push)   ras_ptr <= ras_ptr + RP_W'(1);
    else if (ras_pop)    ras_ptr <= ras_ptr - RP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset && !mispredict && ras_push)
      ras_mem[RAS_IDX_W'(ras_ptr)] <= f_valP;
  end
`else
  logic unused_ras_ptr;

  assign ras_hit        = 1'b0;
  assign ras_top        = '0;
  assign pred_ras_ptr   = '0;
  assign unused_ras_ptr = ^upd_ras_ptr;
`endif

endmodule

// File: doc/y86_branch_predictor.md
Name: y86_branch_predictor

Overview:
- Parametrised dynamic next-PC predictor for the pipelined Y86-64 core.
- Replaces the static always-taken next-PC prediction feeding the F register.
- Sits beside fetch. Lookups are combinational from fetch-stage fields. Training comes from execute-stage conditional-jump resolution.
- Holds a direct-mapped BTB of saturating counters, an optional return-address stack (RAS), and performance counters.

Parameters:
- ADDR_W, 64: PC/address width.
- ENTRIES, 16: BTB entries; power of 2, ≥2. IDX_W = log2(ENTRIES).
- CNT_W, 2: saturating counter width, 1..4.
- MISS_TAKEN, 1: prediction for a conditional jXX on BTB miss (1 = taken).
- RAS_DEPTH, 8: RAS entries; RP_W = clog2(RAS_DEPTH+1).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- f_valid  in  1  fetch holds a real instruction (not a bubble)
- f_stall  in  1  F stage stalled; suppresses all fetch-side state updates
- f_pc  in  ADDR_W  PC of fetched instruction
- f_icode  in  4  fetched icode
- f_ifun  in  4  fetched ifun
- f_valC  in  ADDR_W  fetched constant (jump/call target)
- f_valP  in  ADDR_W  fall-through PC
- predPC  out  ADDR_W  predicted next PC (combinational)
- pred_taken  out  1  prediction for current fetch (combinational)
- pred_ras_ptr  out  RP_W  current RAS pointer; pipeline carries it with the instruction
- upd_valid  in  1  execute resolves a conditional jXX this cycle
- upd_pc  in  ADDR_W  PC of resolving jXX
- upd_cnd  in  1  actual outcome (e_cnd)
- upd_pred_taken  in  1  prediction carried with that jXX
- upd_ras_ptr  in  RP_W  pred_ras_ptr carried with that jXX
- mispredict  out  1  combinational: upd_valid & (upd_cnd != upd_pred_taken)
- lookup_cnt  out  32  conditional-jXX predictions made
- mispred_cnt  out  32  mispredictions

Behaviour:
- Index = pc[IDX_W-1:0]. Tag = pc[ADDR_W-1:IDX_W]. Each entry holds valid, tag, and a CNT_W-bit counter.
- Lookup, icode 7 (jXX):
  - ifun 0 → taken, predPC = f_valC.
  - ifun ≠ 0, BTB hit → taken iff counter MSB = 1.
  - ifun ≠ 0, BTB miss → taken = MISS_TAKEN.
  - Taken → predPC = f_valC; not taken → predPC = f_valP.
- Lookup, icode 8 (call): predPC = f_valC, pred_taken = 1.
- Lookup, icode 9 (ret): see Optional Feature. With the feature absent, predPC = f_valP, pred_taken = 0.
- Lookup, all other icodes: predPC = f_valP, pred_taken = 0.
- Lookup is pure combinational; no state changes when f_valid = 0 or f_stall = 1.
- lookup_cnt increments on each edge where f_valid & !f_stall & f_icode = 7 & f_ifun ≠ 0. Saturates at 2^32−1.
- Update at the clock edge when upd_valid = 1:
  - Hit: counter +1 if upd_cnd, −1 if not; saturates at 0 and 2^CNT_W−1.
  - Miss: allocate. valid = 1, tag written. Counter = 2^(CNT_W−1) if upd_cnd, else 2^(CNT_W−1)−1. Any old entry at that index is overwritten.
  - mispred_cnt increments when mispredict = 1. Saturates at 2^32−1.
- Same-cycle lookup and update to the same index: lookup sees the pre-update value; no bypass.
- Reset: all valid bits 0, counters 0, RAS pointer 0, lookup_cnt 0, mispred_cnt 0. Post-reset outputs are predPC = f_valP (non-branch), pred_taken = 0, mispredict driven only by the inputs.
- reset asserted mid-operation discards all state on that edge; simultaneous update and fetch actions are ignored.
- Latency: prediction available the same cycle as fetch; training visible to lookups from the following cycle.

Optional Feature:
- Macro BPRED_RAS_EN.
- Defined:
  - Call fetch (f_valid & !f_stall & icode 8) pushes f_valP at entry[ptr] and increments ptr.
  - Full stack (ptr = RAS_DEPTH): the push is dropped and ptr is unchanged.
  - Ret fetch with ptr > 0: predPC = entry[ptr−1], pred_taken = 1, ptr decrements on the edge.
  - Ret fetch with ptr = 0: predPC = f_valP, pred_taken = 0, no pop.
  - mispredict = 1 restores ptr to upd_ras_ptr on that edge. A fetch push/pop in the same cycle is dropped; restore wins.
- Undefined:
  - No RAS storage.
  - ret predicts f_valP.
  - pred_ras_ptr is tied to 0; upd_ras_ptr is ignored.

Test Plan:
- Reset, then fetch jXX ifun 1 at pc 0x40, valC 0x100, valP 0x49, MISS_TAKEN = 1 → predPC 0x100, pred_taken 1; lookup_cnt 1 after the edge.
- upd pc 0x40, cnd 0, pred 1 → mispredict 1, mispred_cnt 1. Entry allocated with counter 1. Next fetch at 0x40 → predPC 0x49.
- Two further updates at pc 0x40 with cnd 1 → counter 3, predict taken. Three updates with cnd 0 → counter 0. A fourth cnd 0 → counter stays 0.
- Aliasing: allocate pc 0x40, then update pc 0x50 (ENTRIES = 16, same index, different tag) → 0x40 now misses and predicts per MISS_TAKEN.
- BPRED_RAS_EN: call at 0x10 (valP 0x19), then ret → predPC 0x19, ptr back to 0. Nine calls at depth 8 → ptr 8, ninth push dropped. Ret with empty stack → predPC = valP.
- BPRED_RAS_EN: ptr 2, mispredict with upd_ras_ptr 1, same-cycle call fetch → ptr 1; pushed entry not counted. f_stall = 1 with a call fetch → ptr unchanged.
